// File: rtl/evm_result_uart_tx.sv
// Captures EVM tallies on a show_result rising edge and serialises one 8-byte frame
// (A5, P1..P4, total, winner, XOR checksum of bytes 1..6) as 8N1 UART, LSB first.
module evm_result_uart_tx #(
  parameter int CLK_DIV = 868,
  parameter int COUNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               show_result,
  input  logic [COUNT_W-1:0] vote_party1,
  input  logic [COUNT_W-1:0] vote_party2,
  input  logic [COUNT_W-1:0] vote_party3,
  input  logic [COUNT_W-1:0] vote_party4,
  input  logic [7:0]         total_voting,
  input  logic [1:0]         winner,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic               show_q;
  logic               tx_q, tx_d;
  logic               busy_q, done_q;
  logic               snap;
  logic               baud_wrap;
  logic [COUNT_W-1:0] p1_q, p2_q, p3_q, p4_q;
  logic [7:0]         total_q;
  logic [1:0]         winner_q;
  logic [7:0]         checksum;
  logic [7:0]         cur_byte;

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign checksum  = 8'(p1_q) ^ 8'(p2_q) ^ 8'(p3_q) ^ 8'(p4_q) ^ total_q ^ {6'b0, winner_q};

  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = 8'(p1_q);
      3'd2:    cur_byte = 8'(p2_q);
      3'd3:    cur_byte = 8'(p3_q);
      3'd4:    cur_byte = 8'(p4_q);
      3'd5:    cur_byte = total_q;
      3'd6:    cur_byte = {6'b0, winner_q};
      default: cur_byte = checksum;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap    = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (show_result && !show_q) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          snap    = 1'b1;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (byte_q == 3'd7) begin
            state_d = S_FINISH;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // tx lags the FSM by one cycle, so the start bit appears one edge after the request edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      show_q  <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      show_q  <= show_result;
      tx_q    <= tx_d;
      busy_q  <= (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
      done_q  <= (state_d == S_FINISH);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      p4_q     <= '0;
      total_q  <= '0;
      winner_q <= '0;
    end else if (snap) begin
      p1_q     <= vote_party1;
      p2_q     <= vote_party2;
      p3_q     <= vote_party3;
      p4_q     <= vote_party4;
      total_q  <= total_voting;
      winner_q <= winner;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_evm_result_uart_tx.sv
// Bench for evm_result_uart_tx: one instance at CLK_DIV=4 and one at CLK_DIV=2,
// a UART receiver/busy/done monitor popping expected frames from scoreboard queues.
module tb_evm_result_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       show4, show2;
  logic [5:0] p1, p2, p3, p4;
  logic [7:0] tot;
  logic [1:0] win;
  logic       tx4, busy4, done4;
  logic       tx2, busy2, done2;

  int checks = 0;
  int passes = 0;

  typedef struct packed { logic ch; logic [7:0] dat; } exp_t;
  typedef struct packed { logic ch; logic [15:0] len; } dexp_t;
  exp_t  byteq[$];
  dexp_t doneq[$];

  evm_result_uart_tx #(.CLK_DIV(4), .COUNT_W(6)) u_div4 (
    .clk(clk), .reset(reset), .show_result(show4),
    .vote_party1(p1), .vote_party2(p2), .vote_party3(p3), .vote_party4(p4),
    .total_voting(tot), .winner(win), .tx(tx4), .busy(busy4), .done(done4)
  );

  evm_result_uart_tx #(.CLK_DIV(2), .COUNT_W(6)) u_div2 (
    .clk(clk), .reset(reset), .show_result(show2),
    .vote_party1(p1), .vote_party2(p2), .vote_party3(p3), .vote_party4(p4),
    .total_voting(tot), .winner(win), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Receiver samples every negedge; each bit must hold for exactly its CLK_DIV samples.
  int       rx_st[2], rx_bi[2], rx_cnt[2], busy_run[2];
  logic     rx_val[2], rx_bad[2], prev_done[2];
  logic [7:0] rx_sh[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      rx_st[c] = 0; rx_bi[c] = 0; rx_cnt[c] = 0; busy_run[c] = 0;
      rx_val[c] = 1'b1; rx_bad[c] = 1'b0; prev_done[c] = 1'b0; rx_sh[c] = 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic  t, b, d;
      int    div;
      exp_t  e;
      dexp_t de;
      t   = (c == 1) ? tx2 : tx4;
      b   = (c == 1) ? busy2 : busy4;
      d   = (c == 1) ? done2 : done4;
      div = (c == 1) ? 2 : 4;
      if (!reset) begin
        rx_st[c] = 0;
        busy_run[c] = 0;
        prev_done[c] = 1'b0;
      end else begin
        if (rx_st[c] == 0) begin
          if (!t) begin
            rx_st[c] = 1; rx_bi[c] = 0; rx_cnt[c] = 1; rx_val[c] = 1'b0; rx_bad[c] = 1'b0;
          end
        end else begin
          if (rx_cnt[c] == div) begin
            rx_bi[c]++;
            rx_cnt[c] = 0;
            rx_val[c] = t;
            if (rx_bi[c] <= 8) rx_sh[c][rx_bi[c]-1] = t;
          end else if (t !== rx_val[c]) begin
            rx_bad[c] = 1'b1;
          end
          rx_cnt[c]++;
          if (rx_bi[c] == 9 && rx_cnt[c] == div) begin
            rx_st[c] = 0;
            if (rx_val[c] !== 1'b1) rx_bad[c] = 1'b1;
            if (byteq.size() == 0) begin
              checks++;
              $display("FAIL unexpected byte ch%0d: got %02h required none", c, rx_sh[c]);
            end else begin
              e = byteq.pop_front();
              chk("byte channel", c, e.ch);
              chk("byte value", rx_sh[c], e.dat);
              chk("bit timing", rx_bad[c], 0);
            end
          end
        end
        if (d && prev_done[c]) begin
          checks++;
          $display("FAIL done width ch%0d: high for 2+ cycles, required 1", c);
        end
        if (b) begin
          busy_run[c]++;
        end else if (d) begin
          if (doneq.size() == 0) begin
            checks++;
            $display("FAIL unexpected done ch%0d: got pulse required none", c);
          end else begin
            de = doneq.pop_front();
            chk("done channel", c, de.ch);
            chk("busy length before done", busy_run[c], de.len);
          end
          busy_run[c] = 0;
        end else begin
          busy_run[c] = 0;
        end
        prev_done[c] = d;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] a, b, c, d, input logic [7:0] t, input logic [1:0] w);
    p1 = a; p2 = b; p3 = c; p4 = d; tot = t; win = w;
  endtask

  task automatic push_frame(input logic ch, input logic [63:0] f);
    exp_t  e;
    dexp_t de;
    for (int i = 7; i >= 0; i--) begin
      e.ch = ch;
      e.dat = f[i*8 +: 8];
      byteq.push_back(e);
    end
    de.ch = ch;
    de.len = ch ? 16'd160 : 16'd320;
    doneq.push_back(de);
  endtask

  // Entered just after a posedge; returns 1ns after edge k+2.
  task automatic pulse(input logic ch);
    if (ch) show2 = 1'b1; else show4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy at edge k", ch ? busy2 : busy4, 1);
    chk("tx idle at edge k", ch ? tx2 : tx4, 1);
    @(negedge clk);
    chk("start bit from k+1", ch ? tx2 : tx4, 0);
    @(posedge clk);
    #1;
    if (ch) show2 = 1'b0; else show4 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((byteq.size() != 0 || doneq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n < 3000) passes++;
    else $display("FAIL %s drain: got %0d bytes/%0d dones pending required 0", name, byteq.size(), doneq.size());
    cyc(5);
    chk("tx idle after frame", tx4 & tx2, 1);
    chk("busy low after frame", busy4 | busy2, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    reset = 1'b0; show4 = 1'b0; show2 = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    cyc(3);
    chk("reset tx", {tx4, tx2}, 2'b11);
    chk("reset busy", {busy4, busy2}, 2'b00);
    chk("reset done", {done4, done2}, 2'b00);
    reset = 1'b1;
    cyc(3);
    chk("idle after release", {tx4, busy4, done4}, 3'b100);

    // basic frame
    set_in(5, 12, 0, 63, 80, 3);
    push_frame(0, 64'hA5050C003F500365);
    pulse(0);
    drain("basic");

    // snapshot: inputs cleared at k+10
    push_frame(0, 64'hA5050C003F500365);
    pulse(0);
    cyc(8);
    set_in(0, 0, 0, 0, 0, 0);
    drain("snapshot");

    // edge during busy at k+100 is dropped; a later edge starts a new frame
    set_in(5, 12, 0, 63, 80, 3);
    push_frame(0, 64'hA5050C003F500365);
    pulse(0);
    cyc(98);
    show4 = 1'b1;
    cyc(2);
    show4 = 1'b0;
    drain("busy edge");
    cyc(100);
    set_in(0, 0, 0, 0, 0, 0);
    push_frame(0, 64'hA500000000000000);
    pulse(0);
    drain("all zero");

    // reset mid-frame at k+150, request held high through release
    set_in(63, 63, 63, 63, 255, 0);
    push_frame(0, 64'hA53F3F3F3FFF00FF);
    pulse(0);
    cyc(148);
    reset = 1'b0;
    #1;
    chk("mid-frame reset tx", tx4, 1);
    chk("mid-frame reset busy", busy4, 0);
    chk("mid-frame reset done", done4, 0);
    byteq.delete();
    doneq.delete();
    show4 = 1'b1;
    cyc(3);
    reset = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy4 || !tx4) bcnt++;
    end
    cyc(1);
    chk("no frame on held request", bcnt, 0);
    show4 = 1'b0;
    cyc(2);
    push_frame(0, 64'hA53F3F3F3FFF00FF);
    pulse(0);
    drain("all max");

    // minimum divider
    set_in(5, 12, 0, 63, 80, 3);
    push_frame(1, 64'hA5050C003F500365);
    pulse(1);
    drain("div2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
